kernel33_mac_ctrl: RTL
======================

# kernel33_mac_ctrl

Sequencer that computes one 3x3 convolution point (sum of nine 16x16 pixel-by-kernel products) by time-sharing a single external pipelined 16x16 multiplier. It accepts a packed 3x3 pixel window and 3x3 kernel over a valid/ready handshake. It issues the nine operand pairs to the multiplier in fixed row-major order and accumulates the returned products. It presents the full-precision sum on a valid/ready output. It sits between the window/line-buffer logic and the convolution result sink.

## Interface
- MUL_LAT, 1: multiplier latency in clock edges, 1..4. Operands sampled at edge E give a product that is valid on `mul_result` immediately after edge E+MUL_LAT-1 and is consumed at edge E+MUL_LAT.
- ACC_W, 36: accumulator/result width. It must be ≥36; 9·(2^16−1)^2 < 2^36.

Ports:
- clk  in  1  Single clock. All logic is rising-edge.
- rst  in  1  Synchronous, active-high reset.
- in_valid  in  1  Window/kernel offered.
- in_ready  out  1  Block can accept a window. High only in IDLE.
- im1, im2, im3  in  48  Pixel rows 1..3. Each row packs three unsigned 16-bit pixels; the left pixel is in [47:32], the centre in [31:16], the right in [15:0].
- k1, k2, k3  in  48  Kernel rows, same packing as the pixel rows. Unsigned.
- mul_a, mul_b  out  16  Operands to the shared multiplier.
- mul_en  out  1  Operand pair on mul_a/mul_b is valid this cycle.
- mul_result  in  32  Unsigned product from the multiplier.
- out_valid  out  1  Result valid. Held until accepted.
- out_ready  in  1  Sink accepts the result.
- result  out  ACC_W  Unsigned sum of the nine products.
- busy  out  1  High in any state except IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&in_ready, the block captures all six row inputs into internal registers, clears the accumulator, sets tap=0 and moves to ISSUE.
- ISSUE
  - mul_en=1 and tap counts 0..8. The operands are pixel[tap] and kernel[tap].
  - Tap order: row1 left, centre, right; then row2 left, centre, right; then row3 left, centre, right.
  - At tap 8 the block moves to DRAIN. It moves straight to DONE if MUL_LAT products are already accounted for (see Timing).
- DRAIN
  - mul_en=0, mul_a=mul_b=0.
  - The block waits until all nine products have been accumulated, then moves to DONE.
- DONE
  - out_valid=1 and result is held stable.
  - On out_valid&out_ready the block goes to IDLE next cycle.
- Product tracking:
  - A MUL_LAT-deep valid shift register is fed by mul_en.
  - The accumulator adds zero-extended mul_result on each edge where the register's output bit is 1.
  - Exactly nine additions per window.
- Arithmetic: unsigned, with no wrap for ACC_W≥36.
- Input captures are ignored outside IDLE; in_valid may stay high.
- Reset mid-operation aborts the window. No partial result is ever presented.
- Reset values: state=IDLE, in_ready=1 from the first cycle after reset, out_valid=0, mul_en=0, mul_a=mul_b=0, result=0, busy=0, tap=0, valid shift register cleared.
- While rst is high: in_ready=0.

## Timing
- Accept edge = edge 0.
- mul_en is high for the cycles ending at edges 1..9. Tap t is sampled by the multiplier at edge t+1.
- The last product is accumulated at edge 9+MUL_LAT. out_valid rises at that edge.
- Latency from accept to out_valid: 9+MUL_LAT cycles (10 for MUL_LAT=1).
- If out_ready is already high, the handshake completes at edge 10+MUL_LAT. in_ready is high after that edge.
- Minimum window period is 11+MUL_LAT cycles.
- result and out_valid do not change while out_valid=1 and out_ready=0.
- mul_a/mul_b are registered outputs and change only at edges.

## Test plan
- All pixels 0x0001, all kernel taps 0x0001, MUL_LAT=1 → result=9. out_valid is first seen exactly 10 cycles after acceptance.
- Identity kernel (k2=0x0000_0001_0000, k1=k3=0), im2=0x1111_ABCD_2222 → result=0xABCD.
- All pixels and kernel taps 0xFFFF → result=0x8FFEE0009, with no overflow at ACC_W=36.
- im1=0x0001_0002_0003, im2=0x0004_0005_0006, im3=0x0007_0008_0009, all kernel 0x0001 → the mul_a sequence while mul_en is high is exactly 1,2,…,9 and result=45.
  - Repeat with MUL_LAT=3 → result=45, latency 12.
- Hold out_ready low for 5 cycles after out_valid → result stable and in_ready=0 throughout.
  - Then raise out_ready → one handshake, then IDLE.
  - A second window held on in_valid is accepted on the next cycle.
- Assert rst for one cycle at tap 4 → mul_en=0, out_valid=0, result=0 and state IDLE.
  - A following window of all-ones yields 9, with no residue from the aborted window.

Source files
------------

// File: rtl/kernel33_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : kernel33_mac_ctrl
// Brief   : Computes one 3x3 convolution point by time-sharing an external
//           pipelined 16x16 multiplier; valid/ready in and out.
// Rev     : 1.0 - initial release
// ============================================================================
module kernel33_mac_ctrl #(
    parameter int MUL_LAT = 1,
    parameter int ACC_W   = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [47:0]      im1,
    input  logic [47:0]      im2,
    input  logic [47:0]      im3,
    input  logic [47:0]      k1,
    input  logic [47:0]      k2,
    input  logic [47:0]      k3,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    output logic             mul_en,
    input  logic [31:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             busy
);

    localparam logic [3:0] C_LAST_TAP = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [143:0]       r_pix;
    logic [143:0]       r_krn;
    logic [3:0]         r_tap;
    logic [3:0]         r_cnt;
    logic               r_mul_en;
    logic [15:0]        r_mul_a;
    logic [15:0]        r_mul_b;
    logic [ACC_W-1:0]   r_acc;
    logic [MUL_LAT-1:0] r_vld;
    logic               w_accept;
    logic               w_prod_vld;
    logic               w_last_prod;
    logic [7:0]         w_nxt_off;

    assign w_accept    = in_valid && (r_state == S_IDLE);
    assign w_prod_vld  = r_vld[MUL_LAT-1];
    assign w_last_prod = w_prod_vld && (r_cnt == C_LAST_TAP);
    // Windows are stored row-major with tap 0 in the top lane, so tap t+1
    // lives at lane (7 - t) counting from the bottom.
    assign w_nxt_off   = (r_tap < C_LAST_TAP) ? {4'd7 - r_tap, 4'b0000} : 8'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = !rst;
                busy     = 1'b0;
                if (in_valid) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_tap == C_LAST_TAP) begin
                    w_state_nxt = w_last_prod ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_prod) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tap 0 operands come straight from the ports so the multiplier sees
    // them in the very first cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix    <= '0;
            r_krn    <= '0;
            r_tap    <= '0;
            r_cnt    <= '0;
            r_mul_en <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_acc    <= '0;
        end else if (w_accept) begin
            r_pix    <= {im1, im2, im3};
            r_krn    <= {k1, k2, k3};
            r_tap    <= '0;
            r_cnt    <= '0;
            r_mul_en <= 1'b1;
            r_mul_a  <= im1[47:32];
            r_mul_b  <= k1[47:32];
            r_acc    <= '0;
        end else begin
            if (r_state == S_ISSUE) begin
                if (r_tap == C_LAST_TAP) begin
                    r_mul_en <= 1'b0;
                    r_mul_a  <= '0;
                    r_mul_b  <= '0;
                end else begin
                    r_tap   <= r_tap + 4'd1;
                    r_mul_a <= r_pix[w_nxt_off +: 16];
                    r_mul_b <= r_krn[w_nxt_off +: 16];
                end
            end
            if (w_prod_vld) begin
                r_acc <= r_acc + {{(ACC_W-32){1'b0}}, mul_result};
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    generate
        if (MUL_LAT == 1) begin : g_vld_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= r_mul_en;
                end
            end
        end else begin : g_vld_shift
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld <= '0;
                end else begin
                    r_vld <= {r_vld[MUL_LAT-2:0], r_mul_en};
                end
            end
        end
    endgenerate

    assign mul_en = r_mul_en;
    assign mul_a  = r_mul_a;
    assign mul_b  = r_mul_b;
    assign result = r_acc;

endmodule
`default_nettype wire
